// File: rtl/banco_registros_param.sv
// Parametrised register bank: N x Bits flop storage, one synchronous write port,
// NREAD registered read ports with optional write bypass and hardwired zero register.
module banco_registros_param #(
    parameter int N        = 32,
    parameter int Bits     = 64,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       write_en,
    input  logic [$clog2(N)-1:0]       write_code,
    input  logic [Bits-1:0]            write_data,
    input  logic [NREAD-1:0]           read_en,
    input  logic [NREAD*$clog2(N)-1:0] read_code,
    output logic [NREAD*Bits-1:0]      read_data,
    output logic [NREAD-1:0]           read_valid,
    output logic                       addr_err
);

    localparam int          AW = $clog2(N);
    localparam int unsigned NU = N;

    logic [Bits-1:0]       regs_q [N];
    logic [NREAD*Bits-1:0] read_data_q, read_data_d;
    logic [NREAD-1:0]      read_valid_q, read_valid_d;
    logic                  addr_err_q, addr_err_d;

    logic                  wr_range;
    logic                  wr_ok;
    logic [AW-1:0]         rcode [NREAD];
    logic [NREAD-1:0]      rd_range;

    // A write is only performed when the address exists and is not the hardwired zero.
    always_comb begin
        wr_range = 32'(write_code) < NU;
        wr_ok    = write_en && wr_range && !((ZERO_REG != 0) && (write_code == '0));
    end

    always_comb begin
        for (int p = 0; p < NREAD; p++) begin
            rcode[p]    = read_code[p*AW +: AW];
            rd_range[p] = 32'(rcode[p]) < NU;
        end
    end

    always_comb begin
        read_data_d  = read_data_q;
        read_valid_d = '0;
        addr_err_d   = write_en && !wr_range;
        for (int p = 0; p < NREAD; p++) begin
            if (read_en[p]) begin
                read_valid_d[p] = 1'b1;
                if (!rd_range[p]) begin
                    read_data_d[p*Bits +: Bits] = '0;
                    addr_err_d                  = 1'b1;
                end else if ((ZERO_REG != 0) && (rcode[p] == '0)) begin
                    read_data_d[p*Bits +: Bits] = '0;
                end else if ((BYPASS != 0) && wr_ok && (write_code == rcode[p])) begin
                    read_data_d[p*Bits +: Bits] = write_data;
                end else begin
                    read_data_d[p*Bits +: Bits] = regs_q[rcode[p]];
                end
            end
        end
    end

    // Reset clears every entry, which is why storage is a flop array rather than a RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                regs_q[i] <= '0;
            end
            read_data_q  <= '0;
            read_valid_q <= '0;
            addr_err_q   <= 1'b0;
        end else begin
            if (wr_ok) begin
                regs_q[write_code] <= write_data;
            end
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_banco_registros_param.sv
// Directed bench for banco_registros_param: default instance (bypass, zero reg),
// a no-bypass/no-zero 4-port instance, and an N=24 instance for out-of-range codes.
module tb_banco_registros_param;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults (N=32, NREAD=2, ZERO_REG=1, BYPASS=1)
    logic         a_reset, a_we;
    logic [4:0]   a_wc;
    logic [63:0]  a_wd;
    logic [1:0]   a_ren;
    logic [9:0]   a_rc;
    logic [127:0] a_rd;
    logic [1:0]   a_rv;
    logic         a_err;

    // Instance B: N=32, NREAD=4, ZERO_REG=0, BYPASS=0
    logic         b_reset, b_we;
    logic [4:0]   b_wc;
    logic [63:0]  b_wd;
    logic [3:0]   b_ren;
    logic [19:0]  b_rc;
    logic [255:0] b_rd;
    logic [3:0]   b_rv;
    logic         b_err;

    // Instance C: N=24, NREAD=1, ZERO_REG=1, BYPASS=1
    logic         c_reset, c_we;
    logic [4:0]   c_wc;
    logic [63:0]  c_wd;
    logic [0:0]   c_ren;
    logic [4:0]   c_rc;
    logic [63:0]  c_rd;
    logic [0:0]   c_rv;
    logic         c_err;

    banco_registros_param dut_a (
        .clk(clk), .reset(a_reset), .write_en(a_we), .write_code(a_wc), .write_data(a_wd),
        .read_en(a_ren), .read_code(a_rc), .read_data(a_rd), .read_valid(a_rv), .addr_err(a_err)
    );

    banco_registros_param #(.N(32), .Bits(64), .NREAD(4), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .reset(b_reset), .write_en(b_we), .write_code(b_wc), .write_data(b_wd),
        .read_en(b_ren), .read_code(b_rc), .read_data(b_rd), .read_valid(b_rv), .addr_err(b_err)
    );

    banco_registros_param #(.N(24), .Bits(64), .NREAD(1), .ZERO_REG(1), .BYPASS(1)) dut_c (
        .clk(clk), .reset(c_reset), .write_en(c_we), .write_code(c_wc), .write_data(c_wd),
        .read_en(c_ren), .read_code(c_rc), .read_data(c_rd), .read_valid(c_rv), .addr_err(c_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_reset = 1; a_we = 1; a_wc = 5'd5; a_wd = 64'hFF; a_ren = '0; a_rc = '0;
        b_reset = 1; b_we = 0; b_wc = '0;   b_wd = '0;     b_ren = '0; b_rc = '0;
        c_reset = 1; c_we = 0; c_wc = '0;   c_wd = '0;     c_ren = '0; c_rc = '0;
        tick(); tick();
        check("a_reset_rd",  64'(a_rd), 64'd0);
        check("a_reset_rv",  64'(a_rv), 64'd0);
        check("a_reset_err", 64'(a_err), 64'd0);
        check("c_reset_err", 64'(c_err), 64'd0);

        // 1: write during reset is lost
        a_reset = 0; b_reset = 0; c_reset = 0;
        a_we = 0; a_ren = 2'b01; a_rc = {5'd0, 5'd5};
        tick();
        check("t1_rd0", a_rd[63:0], 64'd0);
        check("t1_rv0", 64'(a_rv), 64'd1);
        check("t1_err", 64'(a_err), 64'd0);

        // 2: basic write then dual-port read, overwrite
        a_ren = '0; a_we = 1; a_wc = 5'd6; a_wd = 64'd32;
        tick();
        a_we = 0; a_ren = 2'b11; a_rc = {5'd6, 5'd6};
        tick();
        check("t2_rd0", a_rd[63:0], 64'd32);
        check("t2_rd1", a_rd[127:64], 64'd32);
        check("t2_rv", 64'(a_rv), 64'd3);
        a_ren = '0; a_we = 1; a_wc = 5'd6; a_wd = 64'd30;
        tick();
        check("t2_hold_rd0", a_rd[63:0], 64'd32);
        check("t2_drop_rv", 64'(a_rv), 64'd0);
        a_we = 0; a_ren = 2'b01; a_rc = {5'd0, 5'd6};
        tick();
        check("t2_rd0_new", a_rd[63:0], 64'd30);

        // 3: same-cycle bypass (A) vs no bypass (B)
        a_we = 1; a_wc = 5'd2; a_wd = 64'd6; a_ren = 2'b10; a_rc = {5'd2, 5'd0};
        b_we = 1; b_wc = 5'd2; b_wd = 64'd6; b_ren = 4'b0010; b_rc = {5'd0, 5'd0, 5'd2, 5'd0};
        tick();
        check("t3_a_bypass", a_rd[127:64], 64'd6);
        check("t3_b_old", b_rd[127:64], 64'd0);
        check("t3_b_rv", 64'(b_rv), 64'd2);
        a_we = 0; a_ren = '0; b_we = 0;
        tick();
        check("t3_b_next", b_rd[127:64], 64'd6);

        // 4: zero register
        a_we = 1; a_wc = 5'd0; a_wd = 64'hDEAD; a_ren = '0;
        b_we = 1; b_wc = 5'd0; b_wd = 64'hDEAD; b_ren = '0;
        tick();
        check("t4_a_wr_err", 64'(a_err), 64'd0);
        a_ren = 2'b01; a_rc = '0; a_wd = 64'hBEEF;  // still writing code 0 while reading it
        b_we = 0; b_ren = 4'b0001; b_rc = '0;
        tick();
        check("t4_a_zero", a_rd[63:0], 64'd0);
        check("t4_a_err", 64'(a_err), 64'd0);
        check("t4_b_dead", b_rd[63:0], 64'hDEAD);
        a_we = 0;

        // 5: hold and valid fall
        a_ren = '0; a_we = 1; a_wc = 5'd3; a_wd = 64'd7;
        tick();
        a_we = 0; a_ren = 2'b01; a_rc = {5'd0, 5'd3};
        tick();
        check("t5_rd0", a_rd[63:0], 64'd7);
        check("t5_rv", 64'(a_rv), 64'd1);
        a_ren = '0;
        tick();
        check("t5_hold1", a_rd[63:0], 64'd7);
        check("t5_rv_fall", 64'(a_rv), 64'd0);
        tick(); tick();
        check("t5_hold3", a_rd[63:0], 64'd7);

        // 5b: four ports, four codes on B
        b_ren = '0;
        for (int i = 0; i < 4; i++) begin
            b_we = 1; b_wc = 5'(10 + i); b_wd = 64'(100 + i);
            tick();
        end
        b_we = 0; b_ren = 4'b1111; b_rc = {5'd13, 5'd12, 5'd11, 5'd10};
        tick();
        check("t5_b_p0", b_rd[63:0],    64'd100);
        check("t5_b_p1", b_rd[127:64],  64'd101);
        check("t5_b_p2", b_rd[191:128], 64'd102);
        check("t5_b_p3", b_rd[255:192], 64'd103);
        check("t5_b_rv", 64'(b_rv), 64'hF);
        b_ren = '0;

        // 6: out of range on C (N=24)
        c_we = 1; c_wc = 5'd22; c_wd = 64'd9;
        tick();
        check("t6_ok_err", 64'(c_err), 64'd0);
        c_wc = 5'd30; c_wd = 64'd55;
        tick();
        check("t6_wr_err", 64'(c_err), 64'd1);
        c_we = 0; c_ren = 1'b1; c_rc = 5'd22;
        tick();
        check("t6_err_clear", 64'(c_err), 64'd0);
        check("t6_r22", c_rd, 64'd9);
        c_rc = 5'd6;
        tick();
        check("t6_r6", c_rd, 64'd0);
        c_rc = 5'd22;
        tick();
        c_rc = 5'd27;
        tick();
        check("t6_r27_rd", c_rd, 64'd0);
        check("t6_r27_rv", 64'(c_rv), 64'd1);
        check("t6_r27_err", 64'(c_err), 64'd1);
        c_rc = 5'd22;
        tick();
        check("t6_r22_again", c_rd, 64'd9);
        c_rc = 5'd27; c_reset = 1;
        tick();
        check("t6_rst_rd", c_rd, 64'd0);
        check("t6_rst_rv", 64'(c_rv), 64'd0);
        check("t6_rst_err", 64'(c_err), 64'd0);
        c_reset = 0; c_rc = 5'd22;
        tick();
        check("t6_rst_storage", c_rd, 64'd0);
        check("t6_rst_rv1", 64'(c_rv), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
